// File: rtl/lcd_panel_model.sv
// Bus-level model of a dual-controller 128x64 graphic LCD.
// It decodes LCD_* strobes into per-half page/column/start-line/display state and a frame buffer.
module lcd_panel_model (
  input  logic        clock,
  input  logic        rst,
  input  logic [7:0]  LCD_DATA,
  input  logic        LCD_ENABLE,
  input  logic        LCD_RW,
  input  logic        LCD_DI,
  input  logic        LCD_CS1,
  input  logic        LCD_CS2,
  input  logic        LCD_RSTN,
  input  logic [9:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [1:0]  disp_on,
  output logic [5:0]  start_line0,
  output logic [5:0]  start_line1,
  output logic [7:0]  stat_dout,
  output logic        stat_oe,
  output logic        cmd_err,
  output logic [15:0] wr_count
);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_DISP_OFF,
    OP_DISP_ON,
    OP_SET_COL,
    OP_SET_PAGE,
    OP_SET_START,
    OP_BAD,
    OP_DATA_WR
  } op_t;

  logic [7:0] s_data;
  logic       s_en, s_en_q, s_en_prev, s_rw, s_di, s_rstn;
  logic [1:0] s_cs;
  logic [7:0] h_data;
  logic       h_rw, h_di;
  logic [1:0] h_cs;

  logic [2:0] page       [2];
  logic [5:0] col        [2];
  logic [5:0] start_line [2];
  logic [1:0] on;

  logic [7:0] ram0 [512];
  logic [7:0] ram1 [512];

  op_t  op;
  logic strobe;

  // s_en_prev only rises after s_en has been high two cycles running,
  // so a single-cycle ENABLE pulse never produces a falling-edge strobe.
  always_ff @(posedge clock) begin
    if (rst) begin
      s_data    <= '0;
      s_en      <= 1'b0;
      s_en_q    <= 1'b0;
      s_en_prev <= 1'b0;
      s_rw      <= 1'b0;
      s_di      <= 1'b0;
      s_cs      <= '0;
      s_rstn    <= 1'b0;
      h_data    <= '0;
      h_rw      <= 1'b0;
      h_di      <= 1'b0;
      h_cs      <= '0;
    end else begin
      s_data    <= LCD_DATA;
      s_en      <= LCD_ENABLE;
      s_en_q    <= s_en;
      s_en_prev <= s_en & s_en_q;
      s_rw      <= LCD_RW;
      s_di      <= LCD_DI;
      s_cs      <= {LCD_CS2, LCD_CS1};
      s_rstn    <= LCD_RSTN;
      if (s_en) begin
        h_data <= s_data;
        h_rw   <= s_rw;
        h_di   <= s_di;
        h_cs   <= s_cs;
      end
    end
  end

  assign strobe = s_en_prev & ~s_en & s_rstn & (|h_cs);

  always_comb begin
    op = OP_NONE;
    if (!h_rw) begin
      if (h_di) begin
        op = OP_DATA_WR;
      end else begin
        casez (h_data)
          8'h3E:        op = OP_DISP_OFF;
          8'h3F:        op = OP_DISP_ON;
          8'b01??????:  op = OP_SET_COL;
          8'b10111???:  op = OP_SET_PAGE;
          8'b11??????:  op = OP_SET_START;
          default:      op = OP_BAD;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned h = 0; h < 2; h++) begin
      if (rst || !s_rstn) begin
        page[h[0]]       <= '0;
        col[h[0]]        <= '0;
        start_line[h[0]] <= '0;
        on[h[0]]         <= 1'b0;
      end else if (strobe && h_cs[h[0]]) begin
        case (op)
          OP_DISP_OFF:  on[h[0]]         <= 1'b0;
          OP_DISP_ON:   on[h[0]]         <= 1'b1;
          OP_SET_COL:   col[h[0]]        <= h_data[5:0];
          OP_SET_PAGE:  page[h[0]]       <= h_data[2:0];
          OP_SET_START: start_line[h[0]] <= h_data[5:0];
          OP_DATA_WR:   col[h[0]]        <= col[h[0]] + 6'd1;
          default:      ;
        endcase
      end
    end
  end

  // One write port per half so a both-CS data strobe lands in both halves at once.
  always_ff @(posedge clock) begin
    if (!rst && strobe && op == OP_DATA_WR) begin
      if (h_cs[0]) ram0[{page[0], col[0]}] <= h_data;
      if (h_cs[1]) ram1[{page[1], col[1]}] <= h_data;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_addr[9] ? ram1[rd_addr[8:0]] : ram0[rd_addr[8:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cmd_err  <= 1'b0;
      wr_count <= '0;
    end else begin
      cmd_err <= strobe && (op == OP_BAD);
      if (strobe && op == OP_DATA_WR && wr_count != '1) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  assign stat_oe   = s_en & s_rw & ~s_di & (|s_cs);
  assign stat_dout = stat_oe ? {2'b00, ~(s_cs[0] ? on[0] : on[1]), ~s_rstn, 4'b0000} : '0;

  assign disp_on     = on;
  assign start_line0 = start_line[0];
  assign start_line1 = start_line[1];

endmodule
